// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared pipeline encodings (writeback select, store size,
//               load kind) and access-size helpers for the EX/MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        ST_WORD = 2'b00,
        ST_HALF = 2'b01,
        ST_BYTE = 2'b10
    } store_src_t;

    typedef enum logic [2:0] {
        LD_LW  = 3'b000,
        LD_LH  = 3'b001,
        LD_LHU = 3'b010,
        LD_LB  = 3'b011,
        LD_LBU = 3'b100
    } load_src_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } acc_size_t;

    // Reserved encodings deliberately fall through to word size.
    function automatic acc_size_t store_size(input logic [1:0] src);
        acc_size_t sz;
        case (src)
            ST_HALF: sz = SZ_HALF;
            ST_BYTE: sz = SZ_BYTE;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic acc_size_t load_size(input logic [2:0] src);
        acc_size_t sz;
        case (src)
            LD_LH, LD_LHU: sz = SZ_HALF;
            LD_LB, LD_LBU: sz = SZ_BYTE;
            default:       sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/align_check.sv
`default_nettype none
// ============================================================================
// Module      : align_check
// Description : Combinational misaligned-access detector for the EX stage.
//               Only instantiated when MISALIGN_TRAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module align_check
    import riscv_pkg::*;
(
    input  logic       i_valid,
    input  logic       i_mem_write,
    input  logic [1:0] i_result_src,
    input  logic [1:0] i_store_src,
    input  logic [2:0] i_load_src,
    input  logic [1:0] i_addr_lo,
    output logic       o_misalign
);

    logic      w_is_access;
    acc_size_t w_size;
    logic      w_offset_bad;

    assign w_is_access = i_mem_write | (i_valid & (i_result_src == RES_MEM));
    assign w_size      = i_mem_write ? store_size(i_store_src) : load_size(i_load_src);

    always_comb begin
        w_offset_bad = 1'b0;
        case (w_size)
            SZ_WORD: w_offset_bad = |i_addr_lo;
            SZ_HALF: w_offset_bad = i_addr_lo[0];
            default: w_offset_bad = 1'b0;
        endcase
    end

    // Bubbles never raise a trap, even if their store flag is stale.
    assign o_misalign = i_valid & w_is_access & w_offset_bad;

endmodule : align_check
`default_nettype wire

// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_reg
// Description : EX/MEM pipeline register with flush/stall control and an
//               optional misaligned-access trap (macro MISALIGN_TRAP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_reg
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteE,
    input  logic                  MemWriteE,
    input  logic                  ValidE,
    input  logic [1:0]            ResultSrcE,
    input  logic [DATA_WIDTH-1:0] ALUResultE,
    input  logic [DATA_WIDTH-1:0] WriteDataE,
    input  logic [DATA_WIDTH-1:0] PCPlus4E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [1:0]            StoreSrcE,
    input  logic [2:0]            LoadSrcE,
    input  logic                  StallM,
    input  logic                  FlushM,
    output logic                  RegWriteM1,
    output logic                  MemWriteM,
    output logic                  ValidM,
    output logic                  MisalignM,
    output logic [1:0]            ResultSrcM1,
    output logic [DATA_WIDTH-1:0] ALUResultM,
    output logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] PCPlus4M1,
    output logic [REG_ADDR_W-1:0] RdM1,
    output logic [1:0]            StoreSrcM,
    output logic [2:0]            LoadSrcM,
    output logic [7:0]            MisalignCnt
);

    localparam logic [7:0] c_cnt_max = 8'hFF;

    logic                  r_reg_write;
    logic                  r_mem_write;
    logic                  r_valid;
    logic [1:0]            r_result_src;
    logic [DATA_WIDTH-1:0] r_alu_result;
    logic [DATA_WIDTH-1:0] r_write_data;
    logic [DATA_WIDTH-1:0] r_pc_plus4;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [1:0]            r_store_src;
    logic [2:0]            r_load_src;
    logic                  w_misalign;

`ifdef MISALIGN_TRAP_EN
    logic       r_misalign;
    logic [7:0] r_misalign_cnt;

    align_check u_align_check (
        .i_valid      (ValidE),
        .i_mem_write  (MemWriteE),
        .i_result_src (ResultSrcE),
        .i_store_src  (StoreSrcE),
        .i_load_src   (LoadSrcE),
        .i_addr_lo    (ALUResultE[1:0]),
        .o_misalign   (w_misalign)
    );

    // The counter survives flushes; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign     <= 1'b0;
            r_misalign_cnt <= 8'd0;
        end else if (FlushM) begin
            r_misalign     <= 1'b0;
        end else if (!StallM) begin
            r_misalign <= w_misalign;
            if (w_misalign && (r_misalign_cnt != c_cnt_max)) begin
                r_misalign_cnt <= r_misalign_cnt + 8'd1;
            end
        end
    end

    assign MisalignM   = r_misalign;
    assign MisalignCnt = r_misalign_cnt;
`else
    assign w_misalign  = 1'b0;
    assign MisalignM   = 1'b0;
    assign MisalignCnt = 8'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_valid      <= 1'b0;
            r_result_src <= 2'b00;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_pc_plus4   <= '0;
            r_rd         <= '0;
            r_store_src  <= 2'b00;
            r_load_src   <= 3'b000;
        end else if (FlushM) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_valid      <= 1'b0;
            r_result_src <= 2'b00;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_pc_plus4   <= '0;
            r_rd         <= '0;
            r_store_src  <= 2'b00;
            r_load_src   <= 3'b000;
        end else if (!StallM) begin
            // A trapped entry must not commit a register or memory write.
            r_reg_write  <= RegWriteE & ~w_misalign;
            r_mem_write  <= MemWriteE & ~w_misalign;
            r_valid      <= ValidE;
            r_result_src <= ResultSrcE;
            r_alu_result <= ALUResultE;
            r_write_data <= WriteDataE;
            r_pc_plus4   <= PCPlus4E;
            r_rd         <= RdE;
            r_store_src  <= StoreSrcE;
            r_load_src   <= LoadSrcE;
        end
    end

    assign RegWriteM1  = r_reg_write;
    assign MemWriteM   = r_mem_write;
    assign ValidM      = r_valid;
    assign ResultSrcM1 = r_result_src;
    assign ALUResultM  = r_alu_result;
    assign WriteDataM  = r_write_data;
    assign PCPlus4M1   = r_pc_plus4;
    assign RdM1        = r_rd;
    assign StoreSrcM   = r_store_src;
    assign LoadSrcM    = r_load_src;

endmodule : ex_mem_reg
`default_nettype wire

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the ALU result, store data and PC+4 fields.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 RegWriteE, MemWriteE, ValidE  in  1 each  execute-stage register-write, memory-write and valid flags.
REQ-005 ResultSrcE  in  2  writeback select: 00 ALU, 01 memory load, 10 PC+4.
REQ-006 ALUResultE, WriteDataE, PCPlus4E  in  DATA_WIDTH each  address/result, store data, PC+4.
REQ-007 RdE  in  5  destination register.
REQ-008 StoreSrcE  in  2  store size: 00 word, 01 half, 10 byte.
REQ-009 LoadSrcE  in  3  load kind: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu.
REQ-010 StallM, FlushM  in  1 each  hold request and bubble request from the hazard unit.
REQ-011 RegWriteM1, MemWriteM, ValidM, MisalignM  out  1 each  registered flags to the memory stage.
REQ-012 ResultSrcM1 (2), ALUResultM, WriteDataM, PCPlus4M1 (DATA_WIDTH), RdM1 (5), StoreSrcM (2), LoadSrcM (3)  out  registered copies of the E inputs.
REQ-013 MisalignCnt  out  8  saturating count of misaligned accesses.

Function
REQ-014 Each clock edge, the block SHALL apply exactly one action, in this priority order: flush, then hold, then load.
REQ-015 Flush (FlushM=1): all outputs except MisalignCnt SHALL become 0 on the next edge, even when StallM=1.
REQ-016 Hold (StallM=1, FlushM=0): every output SHALL keep its value.
REQ-017 Load (otherwise): every M output SHALL take its E counterpart, giving a latency of exactly one cycle; ValidM takes ValidE.
REQ-018 An access SHALL be a memory access when MemWriteE=1, or when ResultSrcE=01 with ValidE=1.
REQ-019 A memory access SHALL be misaligned when it is word-sized with ALUResultE[1:0]!=0, or half-sized with ALUResultE[0]=1.
REQ-020 A byte-sized access SHALL never be misaligned.
REQ-021 Access size SHALL come from StoreSrcE for stores and from LoadSrcE for loads.
REQ-022 StoreSrcE=11 and LoadSrcE values 101-111 are reserved and SHALL be treated as word-sized.
REQ-023 Outputs SHALL be driven only from flops; there SHALL be no combinational path from any input to any output.
REQ-024 A bubble (ValidE=0) SHALL load normally, but SHALL NOT set MisalignM or advance MisalignCnt.

Reset
REQ-025 While rst_n=0, all outputs including MisalignCnt SHALL be 0 immediately (asynchronous), regardless of clk, StallM or FlushM.
REQ-026 Reset asserted mid-operation SHALL discard the held stage contents.
REQ-027 The first edge after rst_n rises SHALL behave as a normal edge.

Configuration
REQ-028 The macro MISALIGN_TRAP_EN SHALL select the misaligned-access trap.
REQ-029 With MISALIGN_TRAP_EN defined, a load of a misaligned access SHALL set MisalignM=1 and force MemWriteM=0 and RegWriteM1=0 for that entry.
REQ-030 With MISALIGN_TRAP_EN defined, each such load SHALL increment MisalignCnt by 1, saturating at 255.
REQ-031 With MISALIGN_TRAP_EN undefined, MisalignM and MisalignCnt SHALL be constant 0, no squash SHALL occur, and no detection logic SHALL be synthesized.

Structure
REQ-032 The ResultSrc, StoreSrc and LoadSrc encodings SHALL be typedef enums in shared package riscv_pkg, alongside a REG_ADDR_W=5 constant.
REQ-033 Alignment detection SHALL be a single sub-module, align_check, that is combinational and used only when MISALIGN_TRAP_EN is defined.

Verification
REQ-034 Plain load: ALUResultE=0x10, RdE=5, RegWriteE=1, ValidE=1, StallM=0 -> after one edge ALUResultM=0x10, RdM1=5, RegWriteM1=1, ValidM=1.
REQ-035 Stall for 3 cycles while E inputs change -> M outputs unchanged for 3 edges, then load the current E values on the 4th edge.
REQ-036 StallM=1 and FlushM=1 in the same cycle -> next edge ValidM=0, MemWriteM=0, RegWriteM1=0, ALUResultM=0.
REQ-037 Trap (MISALIGN_TRAP_EN defined): store word at 0x13 with MemWriteE=1 -> MemWriteM=0, MisalignM=1, MisalignCnt=1. Then sb at 0x13 -> MemWriteM=1, MisalignM=0. Then lh at 0x11 -> RegWriteM1=0, MisalignCnt=2.
REQ-038 Saturation: 300 misaligned lw accesses -> MisalignCnt=255. Then rst_n pulsed low between edges -> all outputs 0 at once.
REQ-039 Macro undefined: store word at 0x13 -> MemWriteM=1, MisalignM=0, MisalignCnt=0.
